// File: rtl/dualport_sram_ctrl_pkg.sv
// Shared definitions for the dual-port SRAM controller.
//   str_state_e : port-1 stream FSM states
//   DEF_*       : default widths/depths used by the controller and its FIFO
package dualport_sram_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } str_state_e;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_NUM_WMASKS = 2;
  localparam int DEF_ADDR_WIDTH = 11;
  localparam int DEF_FIFO_DEPTH = 4;

endpackage

// File: rtl/dualport_sram_ctrl_fifo.sv
// sram_stream_fifo: synchronous FIFO holding port-1 read words plus last flag.
// Ports:
//   clk, rst      clock, synchronous active-high reset (flushes pointers/count)
//   push_i/din_i  write one entry (ignored when full)
//   pop_i         remove head entry (ignored when empty)
//   dout_o        head entry, valid while !empty_o
//   empty_o       no entries stored
//   count_o       number of stored entries
module sram_stream_fifo
  import dualport_sram_ctrl_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH,
  parameter int WIDTH = DEF_DATA_WIDTH + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push_i,
  input  logic [WIDTH-1:0]               din_i,
  input  logic                           pop_i,
  output logic [WIDTH-1:0]               dout_o,
  output logic                           empty_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign do_push = push_i && (count_q != CW'(DEPTH));
  assign do_pop  = pop_i && (count_q != '0);

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/dualport_sram_ctrl.sv
// dualport_sram_ctrl: initiator-side controller for a dual-port SRAM macro.
//   Port 0 (RW): req_* valid/ready channel -> sram_*0 pins; one read outstanding,
//                read data returned on rsp_* two cycles after acceptance.
//   Port 1 (R):  DMA-style streamer; str_start latches str_base/str_len and the
//                block fetches str_len sequential words onto out_* (valid/ready),
//                out_last on the final word, str_done pulses after handoff.
//   All sram_* outputs are registered; clk also clocks the SRAM.
module dualport_sram_ctrl
  import dualport_sram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_WMASKS = DEF_NUM_WMASKS,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [NUM_WMASKS-1:0] req_wmask,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  input  logic                  str_start,
  input  logic [ADDR_WIDTH-1:0] str_base,
  input  logic [ADDR_WIDTH:0]   str_len,
  output logic                  str_busy,
  output logic                  str_done,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  // ---------------- Port 0 ----------------
  logic                  csb0_q, web0_q, req_ready_q, rsp_valid_q;
  logic [NUM_WMASKS-1:0] wmask0_q;
  logic [ADDR_WIDTH-1:0] addr0_q;
  logic [DATA_WIDTH-1:0] din0_q, rsp_data_q;
  logic                  rd_vld_p0_q, rd_vld_p1_q;
  logic                  req_fire;

  assign req_fire = req_valid && req_ready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      csb0_q      <= 1'b1;
      web0_q      <= 1'b1;
      wmask0_q    <= '0;
      addr0_q     <= '0;
      din0_q      <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rd_vld_p0_q <= 1'b0;
      rd_vld_p1_q <= 1'b0;
    end else begin
      // p0: pins driven for exactly one cycle per accepted access
      csb0_q   <= !req_fire;
      web0_q   <= !(req_fire && req_we);
      wmask0_q <= (req_fire && req_we) ? req_wmask : '0;
      if (req_fire) begin
        addr0_q <= req_addr;
        din0_q  <= req_wdata;
      end
      rd_vld_p0_q <= req_fire && !req_we;
      // p1: SRAM has captured the read; dout settles on the negedge
      rd_vld_p1_q <= rd_vld_p0_q;
      // p2: sample dout and hold the response until consumed
      if (rd_vld_p1_q)                   rsp_valid_q <= 1'b1;
      else if (rsp_valid_q && rsp_ready) rsp_valid_q <= 1'b0;
      // Only one read outstanding: block the channel until the response handshake.
      if (req_fire && !req_we)           req_ready_q <= 1'b0;
      else if (rsp_valid_q && rsp_ready) req_ready_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_vld_p1_q) rsp_data_q <= sram_dout0;
  end

  // ---------------- Port 1 ----------------
  str_state_e            state_q;
  logic                  busy_q, done_q, csb1_q;
  logic [ADDR_WIDTH-1:0] addr1_q, base_q;
  logic [ADDR_WIDTH:0]   len_q, n_q;
  logic                  iss_vld_p0_q, iss_vld_p1_q, last_p0_q, last_p1_q;
  logic [1:0]            inflight;
  logic [CW-1:0]         fifo_count;
  logic [CW:0]           occ;
  logic                  issue, last_issue, pop, fifo_empty;
  logic [DATA_WIDTH:0]   fifo_dout;

  assign inflight   = {1'b0, iss_vld_p0_q} + {1'b0, iss_vld_p1_q};
  // Reserve FIFO space for every read still in the SRAM pipeline.
  assign occ        = {1'b0, fifo_count} + {{(CW - 1){1'b0}}, inflight};
  assign issue      = (state_q == S_RUN) && (occ < (CW + 1)'(FIFO_DEPTH));
  assign last_issue = ((n_q + (ADDR_WIDTH + 1)'(1)) == len_q);
  assign pop        = !fifo_empty && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      n_q          <= '0;
      csb1_q       <= 1'b1;
      addr1_q      <= '0;
      iss_vld_p0_q <= 1'b0;
      iss_vld_p1_q <= 1'b0;
      last_p0_q    <= 1'b0;
      last_p1_q    <= 1'b0;
    end else begin
      // p0: read pins for this issue; address wraps modulo 2^ADDR_WIDTH
      csb1_q <= !issue;
      if (issue) addr1_q <= base_q + n_q[ADDR_WIDTH-1:0];
      iss_vld_p0_q <= issue;
      last_p0_q    <= issue && last_issue;
      // p1: SRAM captured; p2 pushes dout1 into the FIFO
      iss_vld_p1_q <= iss_vld_p0_q;
      last_p1_q    <= last_p0_q;
      done_q       <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (str_start) begin
            n_q <= '0;
            if (str_len == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (issue) begin
            n_q <= n_q + (ADDR_WIDTH + 1)'(1);
            if (last_issue) state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // The popped last-flagged word is the final one, so the FIFO is now empty.
          if (pop && fifo_dout[DATA_WIDTH] && (inflight == 2'd0)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((state_q == S_IDLE) && str_start) begin
      base_q <= str_base;
      len_q  <= str_len;
    end
  end

  sram_stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH + 1)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (iss_vld_p1_q),
    .din_i   ({last_p1_q, sram_dout1}),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign str_busy    = busy_q;
  assign str_done    = done_q;
  assign out_valid   = !fifo_empty;
  assign out_data    = fifo_dout[DATA_WIDTH-1:0];
  assign out_last    = !fifo_empty && fifo_dout[DATA_WIDTH];
  assign sram_csb0   = csb0_q;
  assign sram_web0   = web0_q;
  assign sram_wmask0 = wmask0_q;
  assign sram_addr0  = addr0_q;
  assign sram_din0   = din0_q;
  assign sram_csb1   = csb1_q;
  assign sram_addr1  = addr1_q;

endmodule

// File: tb/tb_dualport_sram_ctrl.sv
// Testbench for dualport_sram_ctrl with a behavioural dual-port SRAM model.
// Expected responses are queued at issue time and popped by a monitor on handshakes.
module tb_dualport_sram_ctrl;
  localparam int DW = 16, NM = 2, AW = 11, FD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, req_valid, req_ready, req_we, rsp_valid, rsp_ready;
  logic [NM-1:0] req_wmask, sram_wmask0;
  logic [AW-1:0] req_addr, str_base, sram_addr0, sram_addr1;
  logic [DW-1:0] req_wdata, rsp_data, out_data, sram_din0, sram_dout0, sram_dout1;
  logic          str_start, str_busy, str_done, out_valid, out_ready, out_last;
  logic [AW:0]   str_len;
  logic          sram_csb0, sram_web0, sram_csb1;

  dualport_sram_ctrl #(.DATA_WIDTH(DW), .NUM_WMASKS(NM), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_wmask(req_wmask),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .str_start(str_start), .str_base(str_base), .str_len(str_len),
    .str_busy(str_busy), .str_done(str_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0),
    .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
  );

  // SRAM model: capture on posedge, read data appears on the following negedge.
  logic [DW-1:0] mem [2**AW];
  logic          rd0_pend = 1'b0, rd1_pend = 1'b0;
  logic [AW-1:0] rd0_addr, rd1_addr;

  always @(posedge clk) begin
    if (!sram_csb0 && !sram_web0)
      for (int b = 0; b < NM; b++)
        if (sram_wmask0[b]) mem[sram_addr0][b*8 +: 8] <= sram_din0[b*8 +: 8];
    rd0_pend <= !sram_csb0 && sram_web0;
    rd0_addr <= sram_addr0;
    rd1_pend <= !sram_csb1;
    rd1_addr <= sram_addr1;
  end

  always @(negedge clk) begin
    if (rd0_pend) sram_dout0 <= mem[rd0_addr];
    if (rd1_pend) sram_dout1 <= mem[rd1_addr];
  end

  int tests = 0, fails = 0, out_hs = 0;
  logic [DW-1:0] rsp_exp [$];
  logic [DW:0]   out_exp [$];
  logic [DW-1:0] re;
  logic [DW:0]   oe;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare every handshake against the scoreboard queues.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (rsp_exp.size() == 0) begin
        tests++; fails++;
        $display("FAIL rsp_unexpected: got 0x%0h, expected no response", rsp_data);
      end else begin
        re = rsp_exp.pop_front();
        check("rsp_data", 32'(rsp_data), 32'(re));
      end
    end
    if (!rst && out_valid && out_ready) begin
      out_hs++;
      if (out_exp.size() == 0) begin
        tests++; fails++;
        $display("FAIL out_unexpected: got 0x%0h, expected no word", {out_last, out_data});
      end else begin
        oe = out_exp.pop_front();
        check("out_word{last,data}", 32'({out_last, out_data}), 32'(oe));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic p0_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NM-1:0] m);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d; req_wmask = m;
    tick();
    req_valid = 1'b0; req_we = 1'b0;
  endtask

  task automatic p0_read(input logic [AW-1:0] a, input logic [DW-1:0] exp);
    rsp_exp.push_back(exp);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a;
    tick();
    req_valid = 1'b0;
    check("req_ready_low_after_read", 32'(req_ready), 32'd0);
  endtask

  task automatic exp_word(input logic last, input logic [DW-1:0] d);
    out_exp.push_back({last, d});
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_csb0"},      32'(sram_csb0), 32'd1);
    check({tag, "_web0"},      32'(sram_web0), 32'd1);
    check({tag, "_csb1"},      32'(sram_csb1), 32'd1);
    check({tag, "_wmask0"},    32'(sram_wmask0), 32'd0);
    check({tag, "_addr0"},     32'(sram_addr0), 32'd0);
    check({tag, "_din0"},      32'(sram_din0), 32'd0);
    check({tag, "_addr1"},     32'(sram_addr1), 32'd0);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_busy"},      32'(str_busy), 32'd0);
    check({tag, "_done"},      32'(str_done), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_last"},  32'(out_last), 32'd0);
  endtask

  task automatic run_stream(input logic [AW-1:0] base, input logic [AW:0] len, input bit toggle,
                            output int n_valid, output int first_v, output int last_v,
                            output int n_done, output int done_at);
    n_valid = 0; first_v = -1; last_v = -1; n_done = 0; done_at = -1;
    out_ready = 1'b1;
    str_base = base; str_len = len; str_start = 1'b1;
    tick();
    str_start = 1'b0;
    check("busy_after_start", 32'(str_busy), 32'(len != '0));
    if (str_done) n_done++;
    for (int t = 0; t < 80; t++) begin
      if (toggle) out_ready = t[0];
      tick();
      if (out_valid) begin
        n_valid++;
        if (first_v < 0) first_v = t;
        last_v = t;
      end
      if (str_done) begin n_done++; done_at = t; end
      if (n_done > 0 && t > done_at + 2) break;
    end
    out_ready = 1'b1;
  endtask

  int nv, fv, lv, nd, da, hs0, stray;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_wmask = '0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1; str_start = 1'b0; str_base = '0; str_len = '0; out_ready = 1'b1;
    repeat (3) tick();
    check_reset_vals("reset");
    rst = 1'b0;
    tick();

    // Write then read back through port 0
    p0_write(11'd5, 16'h1234, 2'b11);
    check("wr_pins_csb0",  32'(sram_csb0), 32'd0);
    check("wr_pins_web0",  32'(sram_web0), 32'd0);
    check("wr_pins_addr0", 32'(sram_addr0), 32'd5);
    check("wr_pins_din0",  32'(sram_din0), 32'h1234);
    check("wr_req_ready",  32'(req_ready), 32'd1);
    p0_read(11'd5, 16'h1234);
    check("rd_pins_web0",   32'(sram_web0), 32'd1);
    check("rd_pins_wmask0", 32'(sram_wmask0), 32'd0);
    tick();
    check("rd_lat_cycle1_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rd_csb0_one_cycle", 32'(sram_csb0), 32'd1);
    tick();
    check("rd_lat_cycle2_rsp_valid", 32'(rsp_valid), 32'd1);
    tick();
    check("rsp_valid_cleared", 32'(rsp_valid), 32'd0);
    check("req_ready_returned", 32'(req_ready), 32'd1);

    // Partial-mask write, response held under back-pressure
    p0_write(11'd5, 16'hABCD, 2'b10);
    rsp_ready = 1'b0;
    p0_read(11'd5, 16'hAB34);
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      check("hold_rsp_data", 32'(rsp_data), 32'hAB34);
      check("hold_req_ready", 32'(req_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    check("hold_req_ready_back", 32'(req_ready), 32'd1);

    // Fill mem[i] = i for the streamed regions
    for (int i = 0; i < 8; i++) p0_write(AW'(i), DW'(i), 2'b11);
    p0_write(11'd2046, 16'h07FE, 2'b11);
    p0_write(11'd2047, 16'h07FF, 2'b11);
    tick(); tick();

    // Stream 0..7 with continuous out_ready
    for (int i = 0; i < 8; i++) exp_word(i == 7, DW'(i));
    run_stream(11'd0, 12'd8, 1'b0, nv, fv, lv, nd, da);
    check("s8_first_word_latency", 32'(fv), 32'd2);
    check("s8_valid_cycles", 32'(nv), 32'd8);
    check("s8_back_to_back", 32'(lv - fv), 32'd7);
    check("s8_done_after_last", 32'(da), 32'(lv + 1));
    check("s8_done_pulses", 32'(nd), 32'd1);
    check("s8_busy_dropped", 32'(str_busy), 32'd0);

    // Wrapping stream with 50% back-pressure
    exp_word(1'b0, 16'h07FE); exp_word(1'b0, 16'h07FF);
    exp_word(1'b0, 16'h0000); exp_word(1'b1, 16'h0001);
    run_stream(11'd2046, 12'd4, 1'b1, nv, fv, lv, nd, da);
    check("wrap_done_pulses", 32'(nd), 32'd1);
    check("wrap_all_words_seen", 32'(out_exp.size()), 32'd0);

    // Zero-length stream
    run_stream(11'd3, 12'd0, 1'b0, nv, fv, lv, nd, da);
    check("len0_no_valid", 32'(nv), 32'd0);
    check("len0_done_pulses", 32'(nd), 32'd1);
    check("len0_busy", 32'(str_busy), 32'd0);

    // Reset in the middle of a stream
    for (int i = 0; i < 3; i++) exp_word(1'b0, DW'(i));
    hs0 = out_hs;
    out_ready = 1'b1;
    str_base = 11'd0; str_len = 12'd8; str_start = 1'b1;
    tick();
    str_start = 1'b0;
    for (int t = 0; t < 40; t++) begin
      if (out_hs - hs0 >= 3) break;
      tick();
    end
    check("abort_words_before_rst", 32'(out_hs - hs0), 32'd3);
    rst = 1'b1; out_ready = 1'b0;
    tick();
    check_reset_vals("midrst");
    tick();
    rst = 1'b0; out_ready = 1'b1;
    stray = 0;
    for (int t = 0; t < 6; t++) begin
      tick();
      if (out_valid || str_busy) stray++;
    end
    check("no_late_data_after_rst", 32'(stray), 32'd0);

    // Clean restart
    exp_word(1'b0, 16'd2); exp_word(1'b0, 16'd3); exp_word(1'b1, 16'd4);
    run_stream(11'd2, 12'd3, 1'b0, nv, fv, lv, nd, da);
    check("restart_valid_cycles", 32'(nv), 32'd3);
    check("restart_done_pulses", 32'(nd), 32'd1);

    tick(); tick();
    check("scoreboard_empty", 32'(rsp_exp.size() + out_exp.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
